// File: rtl/counter_pkg.sv
// Shared constants for the up/down modulus counter: direction and boundary-mode
// encodings plus the width helper for the optional prescaler (COUNTER_PRESCALER_EN).
package counter_pkg;

  typedef enum logic {DOWN = 1'b0, UP = 1'b1} dir_e;
  typedef enum logic {WRAP = 1'b0, SAT = 1'b1} mode_e;

  // A prescale of 1 still needs a one-bit register so the port widths stay legal.
  function automatic int presc_width(input int prescale);
    return (prescale <= 1) ? 1 : $clog2(prescale);
  endfunction

endpackage

// File: rtl/count_prescaler.sv
// Divides enabled cycles by PRESCALE; tick marks the enabled cycle that ends a period.
// Only instantiated when COUNTER_PRESCALER_EN is defined.
module count_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PW = presc_width(PRESCALE);
  localparam logic [PW-1:0] LAST_C = PW'(PRESCALE - 1);

  logic [PW-1:0] phase_q, phase_d;

  always_comb begin
    phase_d = phase_q;
    if (clr) begin
      phase_d = '0;
    end else if (en) begin
      phase_d = (phase_q == LAST_C) ? '0 : phase_q + 1'b1;
    end
  end

  assign tick = en && !clr && (phase_q == LAST_C);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down counter over 0..MODULUS-1 with wrap or saturate at the boundary, load clamp,
// terminal-count pulse and sticky boundary flag. COUNTER_PRESCALER_EN adds a step prescaler.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 7,
  parameter int MODULUS  = 100,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  generate
    if (MODULUS < 2 || MODULUS > (1 << WIDTH) || PRESCALE < 1) begin : g_bad_params
      $error("updown_mod_counter: MODULUS must be 2..2**WIDTH and PRESCALE >= 1");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             step;
  logic             at_bound;

`ifdef COUNTER_PRESCALER_EN
  count_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .clr (load),
    .en  (en),
    .tick(step)
  );
`else
  assign step = en;
`endif

  assign at_bound = (up == UP) ? (count_q == MAX_C) : (count_q == '0);

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    if (load) begin
      count_d = (load_val > MAX_C) ? MAX_C : load_val;
      ovf_d   = 1'b0;
    end else if (step) begin
      if (at_bound) begin
        tc_d  = 1'b1;
        ovf_d = 1'b1;
        // Saturate leaves count where it is; wrap jumps to the opposite end.
        if (sat == WRAP) begin
          count_d = (up == UP) ? '0 : MAX_C;
        end
      end else begin
        count_d = (up == UP) ? count_q + 1'b1 : count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter (WIDTH=7, MODULUS=100, PRESCALE=4);
// the prescaler scenario is compiled in only with COUNTER_PRESCALER_EN.
module tb_updown_mod_counter;

  logic       clk = 1'b0;
  logic       rst, en, up, sat, load;
  logic [6:0] load_val;
  logic [6:0] count;
  logic       tc, ovf;

  int errors = 0;
  int checks = 0;

  updown_mod_counter #(.WIDTH(7), .MODULUS(100), .PRESCALE(4)) dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .sat(sat), .load(load),
    .load_val(load_val), .count(count), .tc(tc), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; load = 1'b1; load_val = 7'd50; up = 1'b1; sat = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (count !== 7'd0) begin errors++; $display("FAIL reset_count cyc %0d got %0d want 0", i, count); end
      checks++; if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc cyc %0d got %b want 0", i, tc); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf cyc %0d got %b want 0", i, ovf); end
    end
    rst = 1'b0; load = 1'b0; en = 1'b0;
  endtask

  task automatic test_wrap_up();
    logic [6:0] exp_c;
    en = 1'b1; up = 1'b1; sat = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      exp_c = 7'(i % 100);
      checks++; if (count !== exp_c) begin errors++; $display("FAIL wrap_up_count step %0d got %0d want %0d", i, count, exp_c); end
      checks++; if (tc !== (i == 100)) begin errors++; $display("FAIL wrap_up_tc step %0d got %b want %b", i, tc, (i == 100)); end
      checks++; if (ovf !== (i == 100)) begin errors++; $display("FAIL wrap_up_ovf step %0d got %b want %b", i, ovf, (i == 100)); end
    end
    en = 1'b0;
    tick();
    checks++; if (count !== 7'd0) begin errors++; $display("FAIL hold_count got %0d want 0", count); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL hold_tc got %b want 0", tc); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL hold_ovf_sticky got %b want 1", ovf); end
  endtask

  task automatic test_down_sat();
    rst = 1'b1; tick(); rst = 1'b0;
    en = 1'b1; up = 1'b0; sat = 1'b0;
    tick();
    checks++; if (count !== 7'd99) begin errors++; $display("FAIL down_wrap_count got %0d want 99", count); end
    checks++; if (tc !== 1'b1) begin errors++; $display("FAIL down_wrap_tc got %b want 1", tc); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL down_wrap_ovf got %b want 1", ovf); end
    up = 1'b1; sat = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (count !== 7'd99) begin errors++; $display("FAIL sat_up_count step %0d got %0d want 99", i, count); end
      checks++; if (tc !== 1'b1) begin errors++; $display("FAIL sat_up_tc step %0d got %b want 1", i, tc); end
    end
    up = 1'b0;
    tick();
    checks++; if (count !== 7'd98) begin errors++; $display("FAIL sat_dn_count got %0d want 98", count); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL sat_dn_tc got %b want 0", tc); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL sat_dn_ovf got %b want 1", ovf); end
    load = 1'b1; load_val = 7'd0;
    tick();
    load = 1'b0;
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL load0_ovf got %b want 0", ovf); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (count !== 7'd0) begin errors++; $display("FAIL sat_low_count step %0d got %0d want 0", i, count); end
      checks++; if (tc !== 1'b1) begin errors++; $display("FAIL sat_low_tc step %0d got %b want 1", i, tc); end
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL sat_low_ovf step %0d got %b want 1", i, ovf); end
    end
    sat = 1'b0;
  endtask

  task automatic test_load();
    logic [6:0] vals [4];
    logic [6:0] exps [4];
    vals = '{7'd120, 7'd42, 7'd100, 7'd99};
    exps = '{7'd99,  7'd42, 7'd99,  7'd99};
    en = 1'b1; up = 1'b1; load = 1'b1;
    for (int i = 0; i < 4; i++) begin
      load_val = vals[i];
      tick();
      checks++; if (count !== exps[i]) begin errors++; $display("FAIL load_count val %0d got %0d want %0d", vals[i], count, exps[i]); end
      checks++; if (tc !== 1'b0) begin errors++; $display("FAIL load_tc val %0d got %b want 0", vals[i], tc); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL load_ovf val %0d got %b want 0", vals[i], ovf); end
    end
    load_val = 7'd42;
    tick();
    load = 1'b0;
    tick();
    checks++; if (count !== 7'd43) begin errors++; $display("FAIL post_load_step got %0d want 43", count); end
  endtask

  task automatic test_rst_mid();
    rst = 1'b1; tick(); rst = 1'b0;
    en = 1'b1; up = 1'b1; sat = 1'b0;
    for (int i = 0; i < 57; i++) tick();
    checks++; if (count !== 7'd57) begin errors++; $display("FAIL pre_rst_count got %0d want 57", count); end
    rst = 1'b1;
    tick();
    checks++; if (count !== 7'd0) begin errors++; $display("FAIL mid_rst_count got %0d want 0", count); end
    rst = 1'b0;
    tick();
    checks++; if (count !== 7'd1) begin errors++; $display("FAIL after_rst_count got %0d want 1", count); end
  endtask

  task automatic test_direction_change();
    logic       dirs [4];
    logic [6:0] exps [4];
    dirs = '{1'b1, 1'b0, 1'b0, 1'b1};
    exps = '{7'd6, 7'd5, 7'd4, 7'd5};
    load = 1'b1; load_val = 7'd5; tick(); load = 1'b0;
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      up = dirs[i];
      tick();
      checks++; if (count !== exps[i]) begin errors++; $display("FAIL dir_change step %0d got %0d want %0d", i, count, exps[i]); end
    end
    en = 1'b0;
    tick();
    checks++; if (count !== 7'd5) begin errors++; $display("FAIL dir_hold got %0d want 5", count); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL dir_hold_tc got %b want 0", tc); end
  endtask

`ifdef COUNTER_PRESCALER_EN
  task automatic test_prescaler();
    logic [6:0] exp_c;
    rst = 1'b1; tick(); rst = 1'b0;
    en = 1'b1; up = 1'b1; sat = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_c = 7'(i / 4);
      checks++; if (count !== exp_c) begin errors++; $display("FAIL presc_count cyc %0d got %0d want %0d", i, count, exp_c); end
    end
    tick(); tick();
    en = 1'b0;
    tick(); tick();
    en = 1'b1;
    tick();
    checks++; if (count !== 7'd3) begin errors++; $display("FAIL presc_phase_hold got %0d want 3", count); end
    tick();
    checks++; if (count !== 7'd4) begin errors++; $display("FAIL presc_phase_step got %0d want 4", count); end
  endtask
`endif

  initial begin
    rst = 1'b0; en = 1'b0; up = 1'b1; sat = 1'b0; load = 1'b0; load_val = '0;
    test_reset();
    test_wrap_up();
    test_down_sat();
    test_load();
    test_rst_mid();
    test_direction_change();
`ifdef COUNTER_PRESCALER_EN
    test_prescaler();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/updown_mod_counter.md
UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 7: count register width in bits.
REQ-002 SHALL have parameter MODULUS, default 100: number of count states (0..MODULUS-1); legal range 2..2**WIDTH; an illegal value SHALL fail elaboration.
REQ-003 SHALL have parameter PRESCALE, default 4: enabled cycles per count step; used only when COUNTER_PRESCALER_EN is defined; legal range >=1.
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port en, input, 1: count enable.
REQ-007 SHALL have port up, input, 1: direction, 1 = increment, 0 = decrement.
REQ-008 SHALL have port sat, input, 1: boundary mode, 0 = wrap, 1 = saturate.
REQ-009 SHALL have port load, input, 1: synchronous load strobe.
REQ-010 SHALL have port load_val, input, WIDTH: value to load.
REQ-011 SHALL have port count, output, WIDTH: registered count value.
REQ-012 SHALL have port tc, output, 1: registered terminal-count pulse.
REQ-013 SHALL have port ovf, output, 1: registered sticky boundary flag.

Function
REQ-014 Priority SHALL be rst > load > step > hold, evaluated each rising clk edge.
REQ-015 A step SHALL occur in a cycle with en=1 and the prescale condition true (REQ-028/029); with en=0, count, tc=0, and prescaler state SHALL hold.
REQ-016 Up step: count < MODULUS-1 -> count+1; count == MODULUS-1 -> 0 if sat=0, hold at MODULUS-1 if sat=1.
REQ-017 Down step: count > 0 -> count-1; count == 0 -> MODULUS-1 if sat=0, hold at 0 if sat=1.
REQ-018 tc SHALL be 1 in the cycle following any step taken at the directional boundary (MODULUS-1 up, 0 down), in both modes, and 0 otherwise; repeated boundary steps in saturate mode SHALL give tc=1 each such cycle.
REQ-019 ovf SHALL set on any boundary step and stay set until rst or load.
REQ-020 load SHALL write min(load_val, MODULUS-1) to count, force tc=0, clear ovf, and reset the prescaler, regardless of en.
REQ-021 up or sat changing between cycles SHALL take effect on the next step with no extra latency.
REQ-022 count SHALL never hold a value >= MODULUS.
REQ-023 Latency from input sample to count/tc/ovf change SHALL be exactly one clock.

Reset
REQ-024 With rst=1 at a rising edge: count=0, tc=0, ovf=0, prescaler=0, overriding load and en.
REQ-025 rst asserted mid-count SHALL take effect at the next edge; the first step after rst deasserts SHALL start from 0.
REQ-026 No output SHALL change asynchronously to clk.

Configuration
REQ-027 Macro COUNTER_PRESCALER_EN SHALL select the prescaler.
REQ-028 Defined: an internal counter 0..PRESCALE-1 SHALL advance on each enabled cycle; a step SHALL occur only on the enabled cycle where it equals PRESCALE-1, and it SHALL then return to 0; PRESCALE=1 SHALL behave as undefined.
REQ-029 Undefined: every enabled cycle SHALL be a step; no prescaler logic SHALL be synthesised and PRESCALE SHALL be ignored.

Structure
REQ-030 Package counter_pkg SHALL hold the direction (UP/DOWN) and boundary-mode (WRAP/SAT) constants and the width helper for the prescaler counter (clog2 of PRESCALE).
REQ-031 The prescaler SHALL be sub-module count_prescaler (ports clk, rst, clr, en, tick), instantiated only under COUNTER_PRESCALER_EN.

Verification (WIDTH=7, MODULUS=100, PRESCALE=4)
REQ-032 rst=1 for 3 cycles, en=1, load=1 -> count=0, tc=0, ovf=0 throughout.
REQ-033 From 0, en=1, up=1, sat=0, 100 cycles -> count 99 after cycle 99, 0 after cycle 100, tc=1 that one cycle only, ovf=1 afterwards.
REQ-034 From 0, up=0, sat=0, one step -> count=99, tc=1, ovf=1; then sat=1, up=1 from 99 for 3 steps -> count stays 99, tc=1 each cycle.
REQ-035 load=1, load_val=120, en=1 -> count=99, tc=0, ovf=0; then load_val=42 with load=1 -> count=42, not 43.
REQ-036 Count to 57, then rst=1 for one cycle with en=1 -> count=0; the next enabled cycle gives count=1.
REQ-037 With COUNTER_PRESCALER_EN, en=1 for 12 cycles from 0 -> count=1, 2, 3 after cycles 4, 8, 12; en=0 for 2 cycles mid-period -> prescaler phase held.
